bin_to_bcd_iter: RTL and testbench
==================================

BIN_TO_BCD_ITER -- requirements
Module: bin_to_bcd_iter

Interface
REQ-001 Parameter W, default 16: binary input width; legal range 4..32.
REQ-002 Parameter D, default 5: BCD output digit count; shall satisfy 10^D > 2^W - 1, checked at elaboration with a fatal error otherwise.
REQ-003 Parameter SIGNED, default 0: 1 treats the input as two's complement.
REQ-004 clk  input  1  the only clock; all state changes on its rising edge.
REQ-005 clear  input  1  asynchronous reset, active-low.
REQ-006 in_valid  input  1  a new binary value is offered.
REQ-007 in_ready  output  1  the block can accept a value.
REQ-008 bin_in  input  W  binary value to convert.
REQ-009 out_valid  output  1  a result is held on the outputs.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 bcd  output  4*D  BCD digits; digit k is at bits [4k+3:4k], digit 0 is the least significant.
REQ-012 neg  output  1  the result is negative (SIGNED=1 only; otherwise tied to 0).
REQ-013 digit_en  output  D  significant-digit mask for display blanking.

Function
REQ-014 The FSM shall have three states: IDLE, CONV and DONE.
REQ-015 in_ready shall be high only in IDLE; out_valid shall be high only in DONE.
REQ-016 IDLE to CONV: on the edge where in_valid and in_ready are both high, the block shall capture the magnitude, set neg, clear the BCD scratch and clear the iteration counter.
REQ-017 Magnitude rule: with SIGNED=1 and bin_in[W-1]=1, the magnitude shall be the W-bit two's-complement negation; -2^(W-1) shall yield magnitude 2^(W-1) without overflow. In every other case the magnitude shall be bin_in.
REQ-018 CONV: each edge shall perform exactly one double-dabble iteration. First, add 3 to every scratch nibble greater than 4. Then shift the combined {scratch, magnitude} left by one.
REQ-019 The iteration counter shall be $clog2(W+1) bits wide. After the W-th iteration edge the state shall become DONE.
REQ-020 Latency: out_valid shall rise exactly W cycles after the accept edge.
REQ-021 On entry to DONE the block shall register bcd, neg and digit_en together.
REQ-022 digit_en[k] shall be 1 if digit k or any higher digit is nonzero. digit_en[0] shall always be 1.
REQ-023 DONE to IDLE: on the edge where out_valid and out_ready are both high.
REQ-024 While out_valid=1 and out_ready=0, bcd, neg and digit_en shall be stable.
REQ-025 After the handshake, bcd, neg and digit_en shall hold their last values until the next DONE entry.
REQ-026 In IDLE, out_ready shall be ignored.
REQ-027 In CONV and DONE, in_valid shall be ignored and bin_in shall not be sampled.
REQ-028 A new input shall not be accepted in the same cycle as the output handshake; the minimum input-to-input spacing is W+2 cycles.

Reset
REQ-029 Asserting clear at any time, including mid-CONV, shall immediately force state IDLE, counter 0, scratch 0, bcd 0, neg 0, digit_en 0 and out_valid 0.
REQ-030 in_ready shall be 1 during and after reset.
REQ-031 A partial conversion interrupted by reset shall never be presented as a result.

Structure
REQ-032 A shared package bin_to_bcd_pkg shall hold the state enum and a constant function giving the minimum D for a given W, for use by the elaboration check.
REQ-033 One combinational sub-module, bcd_digit_adj, shall implement the per-nibble add-3 rule and shall be instantiated D times.

Verification
REQ-034 W=8, D=3: accept 255 -> after exactly 8 cycles out_valid=1, bcd=0x255, digit_en=3'b111.
REQ-035 W=8, D=3: accept 0 -> bcd=0x000, digit_en=3'b001.
REQ-036 W=8, D=3, accept 7 -> digit_en=3'b001.
REQ-037 SIGNED=1, W=8, D=3: 0x80 -> neg=1, bcd=0x128. Then 0xFF -> neg=1, bcd=0x001.
REQ-038 Default parameters: 65535 -> bcd=0x65535; hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout; pulse out_ready -> in_ready=1 on the next cycle.
REQ-039 Default parameters: accept 12345, assert clear at iteration 7 -> out_valid stays 0 and in_ready=1; after release, accept 999 -> bcd=0x00999 after 16 cycles.

Source files
------------

// File: rtl/bin_to_bcd_pkg.sv
// Shared types and helpers for the iterative binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  // Number of decimal digits needed to show the largest unsigned w-bit value.
  function automatic int unsigned min_digits(input int unsigned w);
    longint unsigned v;
    int unsigned     d;
    v = (64'd1 << w) - 64'd1;
    d = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      d = d + 1;
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble nibble correction: add 3 to any digit above 4 before the shift.
module bcd_digit_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Pre-shift correction so a digit >= 5 carries into the next nibble after doubling.
  always_comb begin
    nib_o = (nib_i > 4'd4) ? (nib_i + 4'd3) : nib_i;
  end

endmodule

// File: rtl/bin_to_bcd_iter.sv
// Iterative (one bit per clock) binary-to-BCD converter with valid/ready handshakes.
module bin_to_bcd_iter
  import bin_to_bcd_pkg::*;
#(
  parameter int unsigned W      = 16,
  parameter int unsigned D      = 5,
  parameter int unsigned SIGNED = 0
) (
  input  logic           clk,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   bin_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [4*D-1:0] bcd,
  output logic           neg,
  output logic [D-1:0]   digit_en
);

  localparam int unsigned    CntW     = $clog2(W + 1);
  localparam logic [CntW-1:0] LastIter = CntW'(W - 1);

  if ((W < 4) || (W > 32)) begin : g_bad_w
    $fatal(1, "bin_to_bcd_iter: W=%0d outside 4..32", W);
  end
  if (D < min_digits(W)) begin : g_bad_d
    $fatal(1, "bin_to_bcd_iter: D=%0d too small for W=%0d", D, W);
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4*D-1:0]  scratch_q, scratch_d;
  logic [W-1:0]    mag_q, mag_d;
  logic            sign_q, sign_d;
  logic [4*D-1:0]  bcd_q, bcd_d;
  logic            neg_q, neg_d;
  logic [D-1:0]    en_q, en_d;

  logic [4*D-1:0]   adj;
  logic [4*D+W-1:0] shifted;
  logic             in_neg;
  logic [W-1:0]     in_mag;
  logic [D-1:0]     en_next;

  for (genvar g = 0; g < int'(D); g++) begin : g_adj
    bcd_digit_adj u_adj (
      .nib_i (scratch_q[4*g +: 4]),
      .nib_o (adj[4*g +: 4])
    );
  end

  // Input magnitude; W-bit negation maps -2^(W-1) onto 2^(W-1) without loss.
  always_comb begin
    in_neg  = (SIGNED != 0) && bin_in[W-1];
    in_mag  = in_neg ? ((~bin_in) + W'(1)) : bin_in;
    shifted = {adj, mag_q} << 1;
  end

  // Blanking mask from the scratch value that will be latched on DONE entry.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    en_next = '0;
    for (int k = int'(D) - 1; k >= 0; k--) begin
      seen       = seen | (|shifted[W + 4*k +: 4]);
      en_next[k] = seen;
    end
    en_next[0] = 1'b1;
  end

  // Next-state logic for the IDLE/CONV/DONE sequencer and its datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scratch_d = scratch_q;
    mag_d     = mag_q;
    sign_d    = sign_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    en_d      = en_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d   = StConv;
          mag_d     = in_mag;
          sign_d    = in_neg;
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      StConv: begin
        scratch_d = shifted[4*D+W-1:W];
        mag_d     = shifted[W-1:0];
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == LastIter) begin
          state_d = StDone;
          bcd_d   = shifted[4*D+W-1:W];
          neg_d   = sign_q;
          en_d    = en_next;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All state; clear wipes any partial conversion so it can never be presented.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      scratch_q <= '0;
      mag_q     <= '0;
      sign_q    <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      en_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scratch_q <= scratch_d;
      mag_q     <= mag_d;
      sign_q    <= sign_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      en_q      <= en_d;
    end
  end

  // Handshake flags decode straight from the state register.
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    bcd       = bcd_q;
    neg       = neg_q;
    digit_en  = en_q;
  end

endmodule

// File: tb/tb_bin_to_bcd_iter.sv
// Directed bench: W=8 unsigned, W=8 signed and default-parameter instances.
module tb_bin_to_bcd_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear;
  logic [2:0]  iv, ordy, ir, ov;
  logic [7:0]  bin_a, bin_b;
  logic [15:0] bin_c;
  logic [11:0] bcd_a, bcd_b;
  logic [19:0] bcd_c;
  logic        neg_a, neg_b, neg_c;
  logic [2:0]  en_a, en_b;
  logic [4:0]  en_c;

  int n_checks = 0;
  int n_errors = 0;

  bin_to_bcd_iter #(.W(8), .D(3), .SIGNED(0)) u_dut_a (
    .clk(clk), .clear(clear), .in_valid(iv[0]), .in_ready(ir[0]), .bin_in(bin_a),
    .out_valid(ov[0]), .out_ready(ordy[0]), .bcd(bcd_a), .neg(neg_a), .digit_en(en_a)
  );

  bin_to_bcd_iter #(.W(8), .D(3), .SIGNED(1)) u_dut_b (
    .clk(clk), .clear(clear), .in_valid(iv[1]), .in_ready(ir[1]), .bin_in(bin_b),
    .out_valid(ov[1]), .out_ready(ordy[1]), .bcd(bcd_b), .neg(neg_b), .digit_en(en_b)
  );

  bin_to_bcd_iter u_dut_c (
    .clk(clk), .clear(clear), .in_valid(iv[2]), .in_ready(ir[2]), .bin_in(bin_c),
    .out_valid(ov[2]), .out_ready(ordy[2]), .bcd(bcd_c), .neg(neg_c), .digit_en(en_c)
  );

  // Selected-instance view so one set of tasks drives all three.
  int          sel = 0;
  logic        m_ir, m_ov, m_neg;
  logic [19:0] m_bcd;
  logic [4:0]  m_en;
  always_comb begin
    m_ir = 1'b0; m_ov = 1'b0; m_neg = 1'b0; m_bcd = '0; m_en = '0;
    case (sel)
      0: begin m_ir = ir[0]; m_ov = ov[0]; m_neg = neg_a; m_bcd = {8'd0, bcd_a}; m_en = {2'd0, en_a}; end
      1: begin m_ir = ir[1]; m_ov = ov[1]; m_neg = neg_b; m_bcd = {8'd0, bcd_b}; m_en = {2'd0, en_b}; end
      default: begin m_ir = ir[2]; m_ov = ov[2]; m_neg = neg_c; m_bcd = bcd_c; m_en = en_c; end
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer val, then count edges until out_valid (bounded). With noise, in_valid stays
  // high with a different value throughout CONV, which must be ignored.
  task automatic convert(input int s, input logic [15:0] val, input bit noise, output int lat);
    sel = s;
    @(negedge clk);
    check_eq("in_ready_before_accept", 32'(m_ir), 32'd1);
    bin_a = val[7:0]; bin_b = val[7:0]; bin_c = val;
    iv = '0; iv[s] = 1'b1;
    @(posedge clk); #1;
    if (noise) begin
      bin_a = ~val[7:0]; bin_b = ~val[7:0]; bin_c = ~val;
    end else begin
      iv = '0;
    end
    lat = 0;
    while (!m_ov && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    iv = '0;
  endtask

  task automatic take(input int s);
    sel = s;
    @(negedge clk);
    ordy = '0; ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy = '0;
    check_eq("in_ready_after_take", 32'(m_ir), 32'd1);
    check_eq("out_valid_after_take", 32'(m_ov), 32'd0);
  endtask

  task automatic vec(input int s, input logic [15:0] val, input int w, input logic [19:0] e_bcd,
                     input logic e_neg, input logic [4:0] e_en, input bit noise);
    int lat;
    convert(s, val, noise, lat);
    check_eq($sformatf("latency_%0d_%0h", s, val), 32'(lat), 32'(w));
    check_eq($sformatf("bcd_%0d_%0h", s, val), 32'(m_bcd), 32'(e_bcd));
    check_eq($sformatf("neg_%0d_%0h", s, val), 32'(m_neg), 32'(e_neg));
    check_eq($sformatf("digit_en_%0d_%0h", s, val), 32'(m_en), 32'(e_en));
    take(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi_cnt;
    clear = 1'b0; iv = '0; ordy = '0; bin_a = '0; bin_b = '0; bin_c = '0;
    #3;
    check_eq("reset_in_ready", 32'(ir), 32'b111);
    check_eq("reset_out_valid", 32'(ov), 32'b000);
    check_eq("reset_bcd_c", 32'(bcd_c), 32'h0);
    check_eq("reset_en_c", 32'(en_c), 32'h0);
    repeat (2) @(negedge clk);
    clear = 1'b1;

    // W=8 unsigned
    vec(0, 16'd255, 8, 20'h255, 1'b0, 5'b111, 1'b0);
    vec(0, 16'd0,   8, 20'h000, 1'b0, 5'b001, 1'b0);
    vec(0, 16'd7,   8, 20'h007, 1'b0, 5'b001, 1'b0);
    vec(0, 16'd100, 8, 20'h100, 1'b0, 5'b111, 1'b0);
    vec(0, 16'd10,  8, 20'h010, 1'b0, 5'b011, 1'b1);

    // W=8 signed
    vec(1, 16'h0080, 8, 20'h128, 1'b1, 5'b111, 1'b0);
    vec(1, 16'h00FF, 8, 20'h001, 1'b1, 5'b001, 1'b0);
    vec(1, 16'h007F, 8, 20'h127, 1'b0, 5'b111, 1'b0);

    // Default parameters with backpressure
    begin
      int lat;
      convert(2, 16'd65535, 1'b0, lat);
      check_eq("latency_65535", 32'(lat), 32'd16);
      check_eq("bcd_65535", 32'(m_bcd), 32'h65535);
      check_eq("en_65535", 32'(m_en), 32'b11111);
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        check_eq($sformatf("hold_bcd_%0d", i), 32'(m_bcd), 32'h65535);
        check_eq($sformatf("hold_in_ready_%0d", i), 32'(m_ir), 32'd0);
        check_eq($sformatf("hold_out_valid_%0d", i), 32'(m_ov), 32'd1);
      end
      take(2);
      check_eq("after_take_bcd", 32'(m_bcd), 32'h65535);
      check_eq("after_take_en", 32'(m_en), 32'b11111);
    end

    // Reset in the middle of a conversion
    sel = 2;
    @(negedge clk);
    bin_c = 16'd12345; iv[2] = 1'b1;
    @(posedge clk); #1;
    iv = '0;
    repeat (7) @(posedge clk);
    #3 clear = 1'b0;
    #1;
    check_eq("midreset_out_valid", 32'(m_ov), 32'd0);
    check_eq("midreset_in_ready", 32'(m_ir), 32'd1);
    check_eq("midreset_bcd", 32'(m_bcd), 32'h0);
    check_eq("midreset_en", 32'(m_en), 32'h0);
    @(negedge clk);
    clear = 1'b1;
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_ov || !m_ir) hi_cnt++;
    end
    check_eq("no_stale_result", 32'(hi_cnt), 32'd0);
    vec(2, 16'd999, 16, 20'h00999, 1'b0, 5'b00111, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
